// File: rtl/jesd204_rx_link_ctrl_pkg.sv
// jesd204_rx_link_ctrl_pkg: state encoding and counter-width helper for the JESD204 RX link controller.
package jesd204_rx_link_ctrl_pkg;

    localparam int STATE_WIDTH = 3;

    localparam logic [STATE_WIDTH-1:0] RESET      = 3'd0;
    localparam logic [STATE_WIDTH-1:0] WAIT_PHY   = 3'd1;
    localparam logic [STATE_WIDTH-1:0] CHAR_ALIGN = 3'd2;
    localparam logic [STATE_WIDTH-1:0] CGS        = 3'd3;
    localparam logic [STATE_WIDTH-1:0] DATA       = 3'd4;

    typedef enum logic [STATE_WIDTH-1:0] {
        S_RESET      = RESET,
        S_WAIT_PHY   = WAIT_PHY,
        S_CHAR_ALIGN = CHAR_ALIGN,
        S_CGS        = CGS,
        S_DATA       = DATA
    } state_t;

    // Bits needed to hold 0..n, never less than one so zero-sized vectors cannot appear.
    function automatic int cnt_width(input int n);
        return ($clog2(n + 1) > 1) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/jesd204_rx_link_ctrl_timer.sv
// jesd204_rx_link_ctrl_timer: loadable down-counter; o_expired marks the last counting cycle (count == 1).
module jesd204_rx_link_ctrl_timer #(
    parameter int WIDTH = 8
)(
    input  logic             i_clk,
    input  logic             i_resetn,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    output logic             o_expired
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_value;
        else if (r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_expired = (r_cnt == WIDTH'(1));

endmodule

// File: rtl/jesd204_rx_link_ctrl.sv
// jesd204_rx_link_ctrl: JESD204 RX bring-up FSM (PHY ready, char align, CGS, DATA) across NUM_LANES lanes.
// Define JESD204_RX_LINK_CTRL_TIMEOUT_EN to build the CGS timeout, retry counter and sticky timeout flag.
module jesd204_rx_link_ctrl
    import jesd204_rx_link_ctrl_pkg::*;
#(
    parameter int NUM_LANES   = 4,
    parameter int ALIGN_WAIT  = 32,
    parameter int CGS_TIMEOUT = 256,
    parameter int MAX_RETRIES = 3
)(
    input  logic                                i_clk,
    input  logic                                i_resetn,
    input  logic [NUM_LANES-1:0]                i_cfg_lanes_disable,
    input  logic [NUM_LANES-1:0]                i_phy_ready,
    input  logic [NUM_LANES-1:0]                i_cgs_ready,
    output logic [NUM_LANES-1:0]                o_phy_en_char_align,
    output logic [NUM_LANES-1:0]                o_cgs_reset,
    output logic                                o_link_ready,
    output logic [STATE_WIDTH-1:0]              o_status_state,
    output logic [cnt_width(MAX_RETRIES)-1:0]   o_status_retry_cnt,
    output logic                                o_status_timeout
);

`ifdef JESD204_RX_LINK_CTRL_TIMEOUT_EN
    localparam int TMAX = (ALIGN_WAIT > CGS_TIMEOUT) ? ALIGN_WAIT : CGS_TIMEOUT;
`else
    localparam int TMAX = ALIGN_WAIT;
`endif
    localparam int TW = cnt_width(TMAX);
    localparam int RW = cnt_width(MAX_RETRIES);

    state_t                 r_state;
    state_t                 w_next;
    logic [RW-1:0]          r_retry;
    logic [RW-1:0]          w_retry;
    logic                   r_timeout;
    logic                   w_timeout;
    logic [NUM_LANES-1:0]   r_cfg_shadow;
    logic [NUM_LANES-1:0]   w_en;
    logic                   w_phy_ok;
    logic                   w_phy_lost;
    logic                   w_cgs_ok;
    logic                   w_cfg_chg;
    logic                   w_in_link;
    logic                   w_load;
    logic [TW-1:0]          w_load_value;
    logic                   w_expired;

    assign w_en       = ~i_cfg_lanes_disable;
    assign w_phy_ok   = (|w_en) && (&(i_phy_ready | i_cfg_lanes_disable));
    assign w_phy_lost = |(w_en & ~i_phy_ready);
    assign w_cgs_ok   = &(i_cgs_ready | i_cfg_lanes_disable);
    assign w_cfg_chg  = (i_cfg_lanes_disable != r_cfg_shadow);
    assign w_in_link  = (r_state != S_RESET) && (r_state != S_WAIT_PHY);

    // Every state change reloads the shared timer, so a retry re-entry restarts the align wait.
    assign w_load = (w_next != r_state);
`ifdef JESD204_RX_LINK_CTRL_TIMEOUT_EN
    assign w_load_value = (w_next == S_CGS) ? TW'(CGS_TIMEOUT) : TW'(ALIGN_WAIT);
`else
    assign w_load_value = TW'(ALIGN_WAIT);
`endif

    jesd204_rx_link_ctrl_timer #(
        .WIDTH(TW)
    ) u_timer (
        .i_clk        (i_clk),
        .i_resetn     (i_resetn),
        .i_load       (w_load),
        .i_load_value (w_load_value),
        .o_expired    (w_expired)
    );

    always_comb begin
        w_next    = r_state;
        w_retry   = r_retry;
        w_timeout = r_timeout;
        case (r_state)
            S_RESET:      w_next = S_WAIT_PHY;
            S_WAIT_PHY:   w_next = w_phy_ok ? S_CHAR_ALIGN : S_WAIT_PHY;
            S_CHAR_ALIGN: w_next = w_expired ? S_CGS : S_CHAR_ALIGN;
            S_CGS: begin
                if (w_cgs_ok) begin
                    w_next  = S_DATA;
                    w_retry = '0;
                end
`ifdef JESD204_RX_LINK_CTRL_TIMEOUT_EN
                else if (w_expired && r_retry == RW'(MAX_RETRIES)) begin
                    w_next    = S_RESET;
                    w_retry   = '0;
                    w_timeout = 1'b1;
                end else if (w_expired) begin
                    w_next  = S_CHAR_ALIGN;
                    w_retry = r_retry + 1'b1;
                end
`endif
            end
            S_DATA:       w_next = w_cgs_ok ? S_DATA : S_CGS;
            default:      w_next = S_RESET;
        endcase
        // PHY loss outranks everything, then a lane-mask change; both discard the normal transition.
        if (w_in_link && (w_phy_lost || w_cfg_chg)) begin
            w_next    = w_phy_lost ? S_WAIT_PHY : S_RESET;
            w_retry   = r_retry;
            w_timeout = r_timeout;
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state             <= S_RESET;
            r_retry             <= '0;
            r_timeout           <= 1'b0;
            r_cfg_shadow        <= '0;
            o_link_ready        <= 1'b0;
            o_phy_en_char_align <= '0;
            o_cgs_reset         <= '1;
        end else begin
            r_state             <= w_next;
            r_retry             <= w_retry;
            r_timeout           <= w_timeout;
            r_cfg_shadow        <= i_cfg_lanes_disable;
            o_link_ready        <= (w_next == S_DATA);
            o_phy_en_char_align <= (w_next == S_CHAR_ALIGN) ? w_en : '0;
            o_cgs_reset         <= (w_next == S_CGS || w_next == S_DATA) ? i_cfg_lanes_disable : '1;
        end
    end

    assign o_status_state     = r_state;
    assign o_status_retry_cnt = r_retry;
    assign o_status_timeout   = r_timeout;

endmodule

// File: doc/jesd204_rx_link_ctrl.md
# jesd204_rx_link_ctrl

Multi-lane JESD204 receive link bring-up controller. It sequences PHY readiness, character alignment and code-group synchronisation (CGS) across NUM_LANES lanes, with per-lane disable, CGS timeout/retry and loss-of-sync recovery. It sits between the per-lane PHY/CGS logic and the link layer and drives `link_ready` to the data path.

## Interface
- NUM_LANES, 4: number of lanes, 1..32.
- ALIGN_WAIT, 32: cycles `phy_en_char_align` is held before CGS starts, ≥1.
- CGS_TIMEOUT, 256: cycles allowed in CGS before a retry, ≥2.
- MAX_RETRIES, 3: consecutive CGS retries before a full restart, ≥0.

- clk  in  1  link clock.
- resetn  in  1  asynchronous active-low reset.
- cfg_lanes_disable  in  NUM_LANES  1 = lane ignored.
- phy_ready  in  NUM_LANES  per-lane PHY ready.
- cgs_ready  in  NUM_LANES  per-lane CGS complete.
- phy_en_char_align  out  NUM_LANES  per-lane comma alignment enable.
- cgs_reset  out  NUM_LANES  per-lane CGS reset, active high.
- link_ready  out  1  all enabled lanes synchronised.
- status_state  out  3  current state encoding.
- status_retry_cnt  out  clog2(MAX_RETRIES+1)  retries in the current attempt.
- status_timeout  out  1  sticky; a full restart occurred due to retry exhaustion.

## Operation
- States and encodings: RESET=0, WAIT_PHY=1, CHAR_ALIGN=2, CGS=3, DATA=4.
- RESET: held while resetn=0, then for 1 cycle after release. Always goes to WAIT_PHY.
- WAIT_PHY: go to CHAR_ALIGN when all enabled lanes have phy_ready=1 and at least one lane is enabled. With all lanes disabled, the block stays in WAIT_PHY.
- CHAR_ALIGN: timer loads ALIGN_WAIT. Go to CGS on expiry, after exactly ALIGN_WAIT cycles in the state.
- CGS: timer loads CGS_TIMEOUT.
  - Go to DATA when all enabled lanes have cgs_ready=1. This also clears retry_cnt.
  - On expiry with retry_cnt<MAX_RETRIES: increment retry_cnt and go to CHAR_ALIGN.
  - On expiry with retry_cnt=MAX_RETRIES: set status_timeout, clear retry_cnt and go to RESET.
- DATA: link_ready=1.
  - If any enabled lane has cgs_ready=0, go to CGS (retry_cnt unchanged).
- Priority in any state other than RESET/WAIT_PHY:
  - any enabled lane with phy_ready=0 → WAIT_PHY. This has the highest priority, above timer expiry and cgs_ready.
  - a cfg_lanes_disable change → RESET.
- Per-lane outputs for enabled lanes:
  - cgs_reset=1 in RESET, WAIT_PHY and CHAR_ALIGN; 0 in CGS and DATA.
  - phy_en_char_align=1 only in CHAR_ALIGN.
- Per-lane outputs for disabled lanes: cgs_reset=1 and phy_en_char_align=0 always. Their inputs are ignored.
- status_timeout clears only on reset.

## Timing
- Reset values:
  - status_state=0, link_ready=0, phy_en_char_align=0, cgs_reset=all ones, status_retry_cnt=0, status_timeout=0.
  - cfg_lanes_disable shadow register = 0.
- All outputs are registered. Outputs reflect the state register in the same cycle, with no extra pipeline stage.
- Input to state change: one clk edge. A condition true in cycle N gives the new state and outputs in cycle N+1.
- Reset mid-operation: all outputs return to their reset values immediately (asynchronous). Leaving reset is synchronous to clk.
- Timer arithmetic: down-counter, width clog2(max(ALIGN_WAIT,CGS_TIMEOUT)+1). It reloads on every state entry, including re-entry from a retry. Expiry means count=1 while counting, so no wrap-around.
- cfg_lanes_disable is compared against a registered shadow copy every cycle. The shadow updates each cycle.

## Configuration
- JESD204_RX_LINK_CTRL_TIMEOUT_EN
  - Defined: CGS timeout, retry counting and status_timeout are implemented as described.
  - Undefined: CGS waits indefinitely for cgs_ready, and the CGS timer is not built. status_retry_cnt and status_timeout are tied to 0.

## Structure
- Package jesd204_rx_link_ctrl_pkg: state encoding localparams (RESET..DATA), STATE_WIDTH=3, and a counter-width helper function.
- Sub-module jesd204_rx_link_ctrl_timer: loadable down-counter with `load`, `load_value` and an `expired` flag, parametrised by width. It is shared between CHAR_ALIGN and CGS.

## Test plan
All cases use NUM_LANES=4, ALIGN_WAIT=32, CGS_TIMEOUT=256, MAX_RETRIES=3 and the macro defined.
1. Nominal bring-up
   - Stimulus: release resetn; phy_ready=4'hF at cycle 8; cgs_ready=4'hF 20 cycles after CGS entry.
   - Required: phy_en_char_align=4'hF for exactly 32 cycles; cgs_reset falls on CGS entry; link_ready rises 1 cycle after cgs_ready=4'hF.
2. Lane disable
   - Stimulus: cfg_lanes_disable=4'b1000 at reset; lane 3 phy_ready and cgs_ready held at 0.
   - Required: link reaches DATA; lane 3 outputs stay cgs_reset=1 and phy_en_char_align=0.
3. Retry exhaustion
   - Stimulus: cgs_ready held at 0.
   - Required: status_retry_cnt steps 1,2,3 at each 256-cycle expiry; the 4th expiry sets status_timeout=1 and goes to RESET with retry_cnt=0.
4. Loss of sync in DATA
   - Stimulus: drop cgs_ready[1] for 1 cycle.
   - Required: next cycle status_state=3, link_ready=0, cgs_reset=0 held, timer reloaded.
5. PHY loss priority
   - Stimulus: phy_ready[2]=0 in the same cycle the CGS timer expires.
   - Required: WAIT_PHY is entered and status_retry_cnt is not incremented.
6. Asynchronous reset mid-CHAR_ALIGN
   - Stimulus: resetn low between clock edges.
   - Required: outputs at their reset values before the next edge.
